// File: rtl/decoder_sel_arbiter.sv
// decoder_sel_arbiter: round-robin arbiter driving a shared 3->8 select decoder with break-before-make bursts
module decoder_sel_arbiter #(
    parameter int MAX_BURST   = 4,
    parameter int DEAD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] A,
    output logic       N_E1,
    output logic       N_E2,
    output logic       E3,
    output logic [7:0] gnt,
    output logic       busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] DEAD   = 2'd3;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [3:0] DEAD_LAST  = 4'(DEAD_CYCLES - 1);
    logic [1:0] state;
    logic [2:0] idx, ptr, win;
    logic [3:0] cnt;
    logic       en;
    // scan from farthest to nearest so the first set bit after ptr overrides
    always_comb begin
        win = ptr;
        for (int i = 8; i >= 1; i--)
            if (req[ptr + 3'(i)]) win = ptr + 3'(i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            ptr   <= 3'd7;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    idx   <= win;
                    ptr   <= win;
                    state <= SETUP;
                end
                SETUP: begin
                    cnt   <= 4'd0;
                    state <= ACTIVE;
                end
                ACTIVE: if (!req[idx] || cnt == BURST_LAST) begin
                    cnt   <= 4'd0;
                    state <= DEAD;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: if (cnt == DEAD_LAST) begin
                    cnt <= 4'd0;
                    if (|req) begin
                        idx   <= win;
                        ptr   <= win;
                        state <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            endcase
        end
    end
    assign en   = state == ACTIVE;
    assign A    = idx;
    assign N_E1 = ~en;
    assign N_E2 = ~en;
    assign E3   = en;
    assign gnt  = en ? 8'd1 << idx : 8'd0;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_decoder_sel_arbiter.sv
// tb_decoder_sel_arbiter: directed self-checking bench for decoder_sel_arbiter
module tb_decoder_sel_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic [7:0]  req = 8'h00;
    logic [2:0]  A;
    logic        N_E1, N_E2, E3, busy;
    logic [7:0]  gnt;
    logic [14:0] outs, e;
    int errors = 0;
    int checks = 0;

    decoder_sel_arbiter #(.MAX_BURST(4), .DEAD_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .A(A), .N_E1(N_E1), .N_E2(N_E2),
        .E3(E3), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;
    assign outs = {A, N_E1, N_E2, E3, gnt, busy};

    // expected output vector: {A, N_E1, N_E2, E3, gnt, busy}
    function automatic logic [14:0] ex(input logic [2:0] a, input logic en, input logic [7:0] g, input logic b);
        return {a, ~en, ~en, en, g, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        req = 8'h00;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        req = 8'hFF;
        step();
        step();
        e = ex(3'd0, 1'b0, 8'h00, 1'b0); checks++;
        if (outs !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", outs, e); end
        rst = 0;
        step();
        e = ex(3'd0, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL reset_first_setup: got %h expected %h", outs, e); end
        step();
        e = ex(3'd0, 1'b1, 8'h01, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL reset_first_active: got %h expected %h", outs, e); end
        do_reset();
    endtask

    task automatic test_single();
        req = 8'h04;
        step();
        e = ex(3'd2, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL single_setup: got %h expected %h", outs, e); end
        for (int k = 0; k < 4; k++) begin
            step();
            e = ex(3'd2, 1'b1, 8'h04, 1'b1); checks++;
            if (outs !== e) begin errors++; $display("FAIL single_active%0d: got %h expected %h", k, outs, e); end
        end
        step();
        e = ex(3'd2, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL single_dead: got %h expected %h", outs, e); end
        step();
        e = ex(3'd2, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL single_resetup: got %h expected %h", outs, e); end
        step();
        e = ex(3'd2, 1'b1, 8'h04, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL single_period: got %h expected %h", outs, e); end
        do_reset();
    endtask

    task automatic test_all_requesting();
        logic [2:0] g;
        logic [7:0] oh;
        req = 8'hFF;
        step();
        for (int n = 0; n < 9; n++) begin
            g = 3'(n);
            oh = 8'h01 << g;
            e = ex(g, 1'b0, 8'h00, 1'b1); checks++;
            if (outs !== e) begin errors++; $display("FAIL all_setup%0d: got %h expected %h", n, outs, e); end
            for (int k = 0; k < 4; k++) begin
                step();
                e = ex(g, 1'b1, oh, 1'b1); checks++;
                if (outs !== e) begin errors++; $display("FAIL all_active%0d_%0d: got %h expected %h", n, k, outs, e); end
            end
            step();
            e = ex(g, 1'b0, 8'h00, 1'b1); checks++;
            if (outs !== e) begin errors++; $display("FAIL all_dead%0d: got %h expected %h", n, outs, e); end
            step();
        end
        do_reset();
    endtask

    task automatic test_early_release();
        req = 8'h08;
        step();
        e = ex(3'd3, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL early_setup: got %h expected %h", outs, e); end
        step();
        step();
        e = ex(3'd3, 1'b1, 8'h08, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL early_active2: got %h expected %h", outs, e); end
        req = 8'h00;
        step();
        e = ex(3'd3, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL early_dead: got %h expected %h", outs, e); end
        step();
        e = ex(3'd3, 1'b0, 8'h00, 1'b0); checks++;
        if (outs !== e) begin errors++; $display("FAIL early_idle: got %h expected %h", outs, e); end
        step();
        e = ex(3'd3, 1'b0, 8'h00, 1'b0); checks++;
        if (outs !== e) begin errors++; $display("FAIL early_idle_hold: got %h expected %h", outs, e); end
        do_reset();
    endtask

    task automatic test_wrap();
        req = 8'h80;
        step();
        e = ex(3'd7, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL wrap_setup7: got %h expected %h", outs, e); end
        req = 8'h81;
        for (int k = 0; k < 4; k++) begin
            step();
            e = ex(3'd7, 1'b1, 8'h80, 1'b1); checks++;
            if (outs !== e) begin errors++; $display("FAIL wrap_nopreempt%0d: got %h expected %h", k, outs, e); end
        end
        step();
        step();
        e = ex(3'd0, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL wrap_setup0: got %h expected %h", outs, e); end
        for (int k = 0; k < 4; k++) begin
            step();
            e = ex(3'd0, 1'b1, 8'h01, 1'b1); checks++;
            if (outs !== e) begin errors++; $display("FAIL wrap_active0_%0d: got %h expected %h", k, outs, e); end
        end
        step();
        step();
        e = ex(3'd7, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL wrap_back7: got %h expected %h", outs, e); end
        step();
        e = ex(3'd7, 1'b1, 8'h80, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL wrap_active7: got %h expected %h", outs, e); end
        do_reset();
    endtask

    task automatic test_async_reset();
        req = 8'h04;
        step();
        step();
        e = ex(3'd2, 1'b1, 8'h04, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL async_pre: got %h expected %h", outs, e); end
        #2;
        rst = 1;
        #1;
        e = ex(3'd0, 1'b0, 8'h00, 1'b0); checks++;
        if (outs !== e) begin errors++; $display("FAIL async_immediate: got %h expected %h", outs, e); end
        req = 8'h80;
        step();
        rst = 0;
        step();
        e = ex(3'd7, 1'b0, 8'h00, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL async_setup7: got %h expected %h", outs, e); end
        step();
        e = ex(3'd7, 1'b1, 8'h80, 1'b1); checks++;
        if (outs !== e) begin errors++; $display("FAIL async_active7: got %h expected %h", outs, e); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_early_release();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
